// File: rtl/ula_seq_ctrl_if.sv
// Control bundle between the multicycle sequencer and the MIPS-subset datapath.
interface ula_seq_ctrl_if;

   // Instruction fields and ALU flags seen by the sequencer
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;

   // Datapath controls driven by the sequencer
   logic [1:0] ula_a_sel;
   logic [1:0] ula_b_sel;
   logic [2:0] ula_op;
   logic       mem_read;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       ab_write;
   logic       aluout_write;
   logic       reg_write;
   logic       reg_dst;
   logic       epc_write;
   logic       exc_cause;
   logic [3:0] state_dbg;

   // Sequencer side
   modport master (
      input  opcode, funct, zero, overflow,
      output ula_a_sel, ula_b_sel, ula_op, mem_read, ir_write, pc_write, pc_src,
             ab_write, aluout_write, reg_write, reg_dst, epc_write, exc_cause,
             state_dbg
   );

   // Datapath side
   modport slave (
      output opcode, funct, zero, overflow,
      input  ula_a_sel, ula_b_sel, ula_op, mem_read, ir_write, pc_write, pc_src,
             ab_write, aluout_write, reg_write, reg_dst, epc_write, exc_cause,
             state_dbg
   );

endinterface

// File: rtl/ula_seq_ctrl.sv
// Multicycle control sequencer for a MIPS-subset datapath: fetch with fixed
// memory wait states, decode, execute, writeback, branch/jump and exceptions.
// Controls are registered by decoding the state being entered, so they are a
// function of the current state; only pc_write in BRANCH follows zero live.
module ula_seq_ctrl #(
   parameter int unsigned MEM_WAIT = 2
) (
   input logic             clk,
   input logic             reset,
   ula_seq_ctrl_if.master  bus
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;

   localparam logic CAUSE_OVF = 1'b0;
   localparam logic CAUSE_ILL = 1'b1;

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_IRLD   = 4'd2,
      S_DECODE = 4'd3,
      S_EXEC_R = 4'd4,
      S_EXEC_I = 4'd5,
      S_WB_R   = 4'd6,
      S_WB_I   = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_EXC    = 4'd10
   } state_t;

   typedef struct packed {
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      logic [2:0] op;
      logic       mem_read;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ab_write;
      logic       aluout_write;
      logic       reg_write;
      logic       reg_dst;
      logic       epc_write;
      logic       exc_cause;
   } ctrl_t;

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             cause_q, cause_nxt;
   ctrl_t            ctrl_q;

   // Supported R-type functions: add, sub, and
   function automatic logic is_rtype_fn(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
   endfunction

   // Control word asserted while sitting in state st
   function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] fn,
                                         input logic cause);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read = 1'b1;
         end
         S_IRLD: begin
            c.ir_write = 1'b1;
            c.a_sel    = 2'd0;
            c.b_sel    = 2'd1;
            c.op       = ALU_ADD;
            c.pc_src   = 2'd0;
            c.pc_write = 1'b1;
         end
         S_DECODE: begin
            c.ab_write     = 1'b1;
            c.a_sel        = 2'd0;
            c.b_sel        = 2'd3;
            c.op           = ALU_ADD;
            c.aluout_write = 1'b1;
         end
         S_EXEC_R: begin
            c.a_sel        = 2'd1;
            c.b_sel        = 2'd0;
            c.aluout_write = 1'b1;
            case (fn)
               FN_SUB:  c.op = ALU_SUB;
               FN_AND:  c.op = ALU_AND;
               default: c.op = ALU_ADD;
            endcase
         end
         S_EXEC_I: begin
            c.a_sel        = 2'd1;
            c.b_sel        = 2'd2;
            c.op           = ALU_ADD;
            c.aluout_write = 1'b1;
         end
         S_WB_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_WB_I: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b0;
         end
         S_BRANCH: begin
            // pc_write is gated by the live zero flag at the output
            c.a_sel  = 2'd1;
            c.b_sel  = 2'd0;
            c.op     = ALU_SUB;
            c.pc_src = 2'd1;
         end
         S_JUMP: begin
            c.pc_src   = 2'd2;
            c.pc_write = 1'b1;
         end
         S_EXC: begin
            // PC already holds faulting address + 4; ALU forms PC-4 for EPC
            c.a_sel     = 2'd0;
            c.b_sel     = 2'd1;
            c.op        = ALU_SUB;
            c.epc_write = 1'b1;
            c.pc_src    = 2'd3;
            c.pc_write  = 1'b1;
            c.exc_cause = cause;
         end
         default: begin
            c    = '0;
            c.op = ALU_PASS;
         end
      endcase
      return c;
   endfunction

   // Next state, wait counter and exception cause
   always_comb begin
      state_nxt = S_RST;
      cnt_nxt   = cnt_q;
      cause_nxt = cause_q;
      case (state_q)
         S_RST: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_IRLD;
            end else begin
               cnt_nxt   = cnt_q + CNT_W'(1);
               state_nxt = S_FETCH;
            end
         end
         S_IRLD: begin
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (bus.opcode == OP_RTYPE && is_rtype_fn(bus.funct)) begin
               state_nxt = S_EXEC_R;
            end else if (bus.opcode == OP_ADDI) begin
               state_nxt = S_EXEC_I;
            end else if (bus.opcode == OP_BEQ) begin
               state_nxt = S_BRANCH;
            end else if (bus.opcode == OP_J) begin
               state_nxt = S_JUMP;
            end else begin
               state_nxt = S_EXC;
               cause_nxt = CAUSE_ILL;
            end
         end
         S_EXEC_R: begin
            // and cannot overflow, so its flag is ignored
            if (bus.overflow && (bus.funct != FN_AND)) begin
               state_nxt = S_EXC;
               cause_nxt = CAUSE_OVF;
            end else begin
               state_nxt = S_WB_R;
            end
         end
         S_EXEC_I: begin
            if (bus.overflow) begin
               state_nxt = S_EXC;
               cause_nxt = CAUSE_OVF;
            end else begin
               state_nxt = S_WB_I;
            end
         end
         S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_EXC: begin
            state_nxt = S_FETCH;
         end
         default: begin
            state_nxt = S_RST;
         end
      endcase
   end

   // State, counter, cause and registered control word
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RST;
         cnt_q   <= '0;
         cause_q <= 1'b0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         cause_q <= cause_nxt;
         ctrl_q  <= decode_ctrl(state_nxt, bus.funct, cause_nxt);
      end
   end

   // Drive the datapath controls
   assign bus.ula_a_sel    = ctrl_q.a_sel;
   assign bus.ula_b_sel    = ctrl_q.b_sel;
   assign bus.ula_op       = ctrl_q.op;
   assign bus.mem_read     = ctrl_q.mem_read;
   assign bus.ir_write     = ctrl_q.ir_write;
   assign bus.pc_write     = ctrl_q.pc_write | ((state_q == S_BRANCH) & bus.zero);
   assign bus.pc_src       = ctrl_q.pc_src;
   assign bus.ab_write     = ctrl_q.ab_write;
   assign bus.aluout_write = ctrl_q.aluout_write;
   assign bus.reg_write    = ctrl_q.reg_write;
   assign bus.reg_dst      = ctrl_q.reg_dst;
   assign bus.epc_write    = ctrl_q.epc_write;
   assign bus.exc_cause    = ctrl_q.exc_cause;
   assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl: two instances (MEM_WAIT=2 and MEM_WAIT=1), a table of
// directed instructions, random instructions against a trace model, and
// hand-written reset sequences.
module tb_ula_seq_ctrl;

   localparam logic [3:0] ST_RST = 4'd0,  ST_FETCH = 4'd1, ST_IRLD = 4'd2,
                          ST_DECODE = 4'd3, ST_EXEC_R = 4'd4, ST_EXEC_I = 4'd5,
                          ST_WB_R = 4'd6, ST_WB_I = 4'd7, ST_BRANCH = 4'd8,
                          ST_JUMP = 4'd9, ST_EXC = 4'd10;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      logic [2:0] op;
      logic       mem_read;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ab_write;
      logic       aluout_write;
      logic       reg_write;
      logic       reg_dst;
      logic       epc_write;
      logic       exc_cause;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       ov;
      int         lat_extra;
   } vec_t;

   logic       clk;
   logic       rst_a, rst_b;
   logic       sel_b;
   logic [5:0] opcode, funct;
   logic       zero, overflow;

   int n_chk;
   int n_fail;

   logic [3:0] tr[$];
   logic       tr_cause;

   ula_seq_ctrl_if bus_a ();
   ula_seq_ctrl_if bus_b ();

   assign bus_a.opcode   = opcode;
   assign bus_a.funct    = funct;
   assign bus_a.zero     = zero;
   assign bus_a.overflow = overflow;
   assign bus_b.opcode   = opcode;
   assign bus_b.funct    = funct;
   assign bus_b.zero     = zero;
   assign bus_b.overflow = overflow;

   ula_seq_ctrl #(.MEM_WAIT(2)) u_dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.master));
   ula_seq_ctrl #(.MEM_WAIT(1)) u_dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.master));

   obs_t obs_a, obs_b, obs;

   assign obs_a = {bus_a.state_dbg, bus_a.ula_a_sel, bus_a.ula_b_sel, bus_a.ula_op,
                   bus_a.mem_read, bus_a.ir_write, bus_a.pc_write, bus_a.pc_src,
                   bus_a.ab_write, bus_a.aluout_write, bus_a.reg_write, bus_a.reg_dst,
                   bus_a.epc_write, bus_a.exc_cause};
   assign obs_b = {bus_b.state_dbg, bus_b.ula_a_sel, bus_b.ula_b_sel, bus_b.ula_op,
                   bus_b.mem_read, bus_b.ir_write, bus_b.pc_write, bus_b.pc_src,
                   bus_b.ab_write, bus_b.aluout_write, bus_b.reg_write, bus_b.reg_dst,
                   bus_b.epc_write, bus_b.exc_cause};
   assign obs = sel_b ? obs_b : obs_a;

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle spent in state st
   function automatic obs_t exp_obs(input logic [3:0] st, input logic [5:0] fn,
                                    input logic z, input logic cause);
      obs_t o;
      o    = '0;
      o.st = st;
      case (st)
         ST_FETCH:  o.mem_read = 1'b1;
         ST_IRLD:   begin o.ir_write = 1'b1; o.b_sel = 2'd1; o.op = 3'd1; o.pc_write = 1'b1; end
         ST_DECODE: begin o.ab_write = 1'b1; o.b_sel = 2'd3; o.op = 3'd1; o.aluout_write = 1'b1; end
         ST_EXEC_R: begin
            o.a_sel = 2'd1; o.aluout_write = 1'b1;
            o.op = (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd1;
         end
         ST_EXEC_I: begin o.a_sel = 2'd1; o.b_sel = 2'd2; o.op = 3'd1; o.aluout_write = 1'b1; end
         ST_WB_R:   begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
         ST_WB_I:   o.reg_write = 1'b1;
         ST_BRANCH: begin o.a_sel = 2'd1; o.op = 3'd2; o.pc_src = 2'd1; o.pc_write = z; end
         ST_JUMP:   begin o.pc_src = 2'd2; o.pc_write = 1'b1; end
         ST_EXC:    begin
            o.b_sel = 2'd1; o.op = 3'd2; o.epc_write = 1'b1;
            o.pc_src = 2'd3; o.pc_write = 1'b1; o.exc_cause = cause;
         end
         default:   o = '0;
      endcase
      return o;
   endfunction

   // Sequence of states an instruction visits, from its first FETCH cycle
   task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                              input logic ov, input int mw);
      logic legal_r;
      tr.delete();
      tr_cause = 1'b0;
      for (int i = 0; i < mw; i++) tr.push_back(ST_FETCH);
      tr.push_back(ST_IRLD);
      tr.push_back(ST_DECODE);
      legal_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
      if (legal_r) begin
         tr.push_back(ST_EXEC_R);
         if (ov && fn != 6'h24) tr.push_back(ST_EXC);
         else                   tr.push_back(ST_WB_R);
      end else if (op == 6'h08) begin
         tr.push_back(ST_EXEC_I);
         tr.push_back(ov ? ST_EXC : ST_WB_I);
      end else if (op == 6'h04) begin
         tr.push_back(ST_BRANCH);
      end else if (op == 6'h02) begin
         tr.push_back(ST_JUMP);
      end else begin
         tr.push_back(ST_EXC);
         tr_cause = 1'b1;
      end
   endtask

   // Run one instruction starting at a negedge showing its first FETCH cycle
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic ov, input int mw, input int lat);
      int         dut_len;
      logic [3:0] prev;
      opcode   = op;
      funct    = fn;
      zero     = z;
      overflow = ov;
      build_trace(op, fn, ov, mw);
      if (lat < 0) lat = tr.size();
      dut_len = 0;
      prev    = ST_FETCH;
      for (int i = 0; i < tr.size(); i++) begin
         chk($sformatf("%s cyc%0d", tag, i), 32'(obs),
             32'(exp_obs(tr[i], fn, z, tr_cause)));
         if (i > 0 && dut_len == 0 && prev != ST_FETCH && obs.st == ST_FETCH) dut_len = i;
         prev = obs.st;
         @(negedge clk);
      end
      if (dut_len == 0 && obs.st == ST_FETCH) dut_len = tr.size();
      chk($sformatf("%s latency", tag), 32'(dut_len), 32'(lat));
   endtask

   task automatic run_table(input string tag, input int mw);
      vec_t tbl[10];
      tbl[0] = '{6'h00, 6'h22, 1'b0, 1'b0, 4};  // sub
      tbl[1] = '{6'h00, 6'h20, 1'b0, 1'b0, 4};  // add
      tbl[2] = '{6'h04, 6'h00, 1'b1, 1'b0, 3};  // beq taken
      tbl[3] = '{6'h04, 6'h00, 1'b0, 1'b0, 3};  // beq not taken
      tbl[4] = '{6'h08, 6'h00, 1'b0, 1'b1, 4};  // addi overflow
      tbl[5] = '{6'h3F, 6'h00, 1'b0, 1'b0, 3};  // illegal opcode
      tbl[6] = '{6'h00, 6'h24, 1'b0, 1'b1, 4};  // and ignores overflow
      tbl[7] = '{6'h00, 6'h20, 1'b0, 1'b1, 4};  // add overflow
      tbl[8] = '{6'h02, 6'h00, 1'b1, 1'b1, 3};  // jump, flags ignored
      tbl[9] = '{6'h00, 6'h21, 1'b0, 1'b0, 3};  // unsupported funct
      for (int k = 0; k < 10; k++)
         run_instr($sformatf("%s vec%0d", tag, k), tbl[k].op, tbl[k].fn, tbl[k].z,
                   tbl[k].ov, mw, mw + tbl[k].lat_extra);
   endtask

   task automatic run_random(input string tag, input int mw, input int n);
      logic [5:0] op, fn;
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 4))
            0:       op = 6'h00;
            1:       op = 6'h08;
            2:       op = 6'h04;
            3:       op = 6'h02;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            default: fn = 6'($urandom);
         endcase
         run_instr($sformatf("%s rnd%0d op%0h fn%0h", tag, k, op, fn), op, fn,
                   1'($urandom), 1'($urandom), mw, -1);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      sel_b    = 1'b0;
      rst_a    = 1'b1;
      rst_b    = 1'b1;
      opcode   = 6'h00;
      funct    = 6'h00;
      zero     = 1'b1;
      overflow = 1'b1;

      // Reset held three cycles: state 0, every output 0
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("a reset cyc%0d", i), 32'(obs), 32'(exp_obs(ST_RST, 6'h00, 1'b0, 1'b0)));
      end
      rst_a = 1'b0;
      @(negedge clk);

      run_table("a", 2);
      run_random("a", 2, 25);

      // Reset asserted while in EXEC_R
      opcode = 6'h00; funct = 6'h20; zero = 1'b0; overflow = 1'b0;
      build_trace(6'h00, 6'h20, 1'b0, 2);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("a midrst cyc%0d", i), 32'(obs), 32'(exp_obs(tr[i], 6'h20, 1'b0, 1'b0)));
         if (i < 4) @(negedge clk);
      end
      rst_a = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("a midrst held%0d", i), 32'(obs), 32'(exp_obs(ST_RST, 6'h20, 1'b0, 1'b0)));
      end
      rst_a = 1'b0;
      @(negedge clk);
      run_instr("a after_rst", 6'h00, 6'h22, 1'b0, 1'b0, 2, 6);

      // Second instance: one-cycle fetch
      rst_a = 1'b1;
      sel_b = 1'b1;
      #1;
      chk("b reset", 32'(obs), 32'(exp_obs(ST_RST, 6'h00, 1'b0, 1'b0)));
      rst_b = 1'b0;
      @(negedge clk);
      run_table("b", 1);
      run_random("b", 1, 25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard time limit
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
